// File: rtl/instr_mem_arbiter.sv
// Instruction-memory port arbiter: fetch reads vs. loader writes,
// one outstanding transaction, fetch priority bounded by starvation count.
module instr_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iFetchValid,
    input  logic [ADDR_W-1:0] iFetchAddr,
    input  logic              iFetchFlush,
    output logic              oFetchReady,
    output logic [DATA_W-1:0] oFetchData,
    input  logic              iLoadValid,
    input  logic [ADDR_W-1:0] iLoadAddr,
    input  logic [DATA_W-1:0] iLoadData,
    output logic              oLoadReady,
    input  logic              iHalt,
    output logic [ADDR_W-1:0] oMemAddress,
    output logic [DATA_W-1:0] oMemData,
    output logic              oMemWrite,
    output logic              oMemValid,
    input  logic [DATA_W-1:0] iMemData,
    input  logic              iMemReady,
    output logic [1:0]        oGrant,
    output logic              oBusErr
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GNT_FETCH = 2'b01,
        GNT_LOAD  = 2'b10
    } state_e;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);
    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              write_q, write_d;
    logic [7:0]        starve_q, starve_d;
    logic [7:0]        tmo_q, tmo_d;
    logic              drop_q, drop_d;
    logic              err_q, err_d;
    logic              err_fetch_q, err_fetch_d;
    logic              err_load_q, err_load_d;

    logic              load_win;
    logic              drop_now;
    logic [7:0]        tmo_inc;
    logic              fetch_gnt;
    logic              load_gnt;
    logic              fetch_rdy;
    logic              load_rdy;
    logic [DATA_W-1:0] fetch_dat;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        data_d      = data_q;
        write_d     = write_q;
        tmo_d       = tmo_q;
        drop_d      = drop_q;
        err_d       = 1'b0;
        err_fetch_d = 1'b0;
        err_load_d  = 1'b0;
        fetch_gnt   = 1'b0;
        load_gnt    = 1'b0;
        fetch_rdy   = 1'b0;
        load_rdy    = 1'b0;
        fetch_dat   = '0;
        drop_now    = drop_q | iFetchFlush;
        tmo_inc     = tmo_q + 8'd1;
        load_win    = iLoadValid &&
                      (starve_q >= STARVE_LIM || !iFetchValid || iHalt);

        unique case (state_q)
            IDLE: begin
                tmo_d  = '0;
                drop_d = 1'b0;
                // The aborted requester still holds valid during its
                // error-ready cycle, so arbitration waits one cycle.
                if (!err_q) begin
                    if (load_win) begin
                        load_gnt = 1'b1;
                        state_d  = GNT_LOAD;
                        addr_d   = iLoadAddr;
                        data_d   = iLoadData;
                        write_d  = 1'b1;
                    end else if (iFetchValid && !iHalt) begin
                        fetch_gnt = 1'b1;
                        state_d   = GNT_FETCH;
                        addr_d    = iFetchAddr;
                        data_d    = '0;
                        write_d   = 1'b0;
                    end
                end
            end
            GNT_FETCH: begin
                if (iMemReady) begin
                    fetch_rdy = !drop_now;
                    fetch_dat = iMemData;
                    state_d   = IDLE;
                    drop_d    = 1'b0;
                end else if (tmo_inc == TMO_LIM) begin
                    state_d     = IDLE;
                    drop_d      = 1'b0;
                    err_d       = 1'b1;
                    err_fetch_d = !drop_now;
                end else begin
                    tmo_d  = tmo_inc;
                    drop_d = drop_now;
                end
            end
            GNT_LOAD: begin
                if (iMemReady) begin
                    load_rdy = 1'b1;
                    state_d  = IDLE;
                end else if (tmo_inc == TMO_LIM) begin
                    state_d    = IDLE;
                    err_d      = 1'b1;
                    err_load_d = 1'b1;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!iLoadValid || load_gnt) begin
            starve_d = '0;
        end else if (fetch_gnt && starve_q < STARVE_LIM) begin
            starve_d = starve_q + 8'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            write_q     <= 1'b0;
            starve_q    <= '0;
            tmo_q       <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            err_fetch_q <= 1'b0;
            err_load_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            write_q     <= write_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            err_fetch_q <= err_fetch_d;
            err_load_q  <= err_load_d;
        end
    end

    assign oFetchReady = fetch_rdy | err_fetch_q;
    assign oFetchData  = fetch_dat;
    assign oLoadReady  = load_rdy | err_load_q;
    assign oBusErr     = err_q;
    assign oMemValid   = (state_q != IDLE);
    assign oGrant      = state_q;
    assign oMemAddress = addr_q;
    assign oMemData    = data_q;
    assign oMemWrite   = write_q;

endmodule

// File: tb/tb_instr_mem_arbiter.sv
// Directed bench for instr_mem_arbiter (STARVE_MAX=8, TIMEOUT=4):
// per-cycle vector table plus contention and async-reset sequences.
module tb_instr_mem_arbiter;

    logic        iClk = 1'b0;
    logic        iRst_n;
    logic        iFetchValid;
    logic [31:0] iFetchAddr;
    logic        iFetchFlush;
    logic        oFetchReady;
    logic [31:0] oFetchData;
    logic        iLoadValid;
    logic [31:0] iLoadAddr;
    logic [31:0] iLoadData;
    logic        oLoadReady;
    logic        iHalt;
    logic [31:0] oMemAddress;
    logic [31:0] oMemData;
    logic        oMemWrite;
    logic        oMemValid;
    logic [31:0] iMemData;
    logic        iMemReady;
    logic [1:0]  oGrant;
    logic        oBusErr;

    int n_chk  = 0;
    int n_fail = 0;

    instr_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(8), .TIMEOUT(4)
    ) dut (
        .iClk(iClk), .iRst_n(iRst_n),
        .iFetchValid(iFetchValid), .iFetchAddr(iFetchAddr),
        .iFetchFlush(iFetchFlush), .oFetchReady(oFetchReady),
        .oFetchData(oFetchData), .iLoadValid(iLoadValid),
        .iLoadAddr(iLoadAddr), .iLoadData(iLoadData),
        .oLoadReady(oLoadReady), .iHalt(iHalt),
        .oMemAddress(oMemAddress), .oMemData(oMemData),
        .oMemWrite(oMemWrite), .oMemValid(oMemValid),
        .iMemData(iMemData), .iMemReady(iMemReady),
        .oGrant(oGrant), .oBusErr(oBusErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic        fv;
        logic [31:0] fa;
        logic        fl;
        logic        lv;
        logic [31:0] la;
        logic [31:0] ld;
        logic        h;
        logic        mr;
        logic [31:0] md;
        logic [102:0] exp;
    } vec_t;

    vec_t vq[$];

    // {fr, fd, lr, mv, maddr, mdata, mw, grant, buserr}
    function automatic logic [102:0] outs();
        return {oFetchReady, oFetchData, oLoadReady, oMemValid,
                oMemAddress, oMemData, oMemWrite, oGrant, oBusErr};
    endfunction

    function automatic vec_t mk(
        input logic [31:0] fv, fa, fl, lv, la, ld, h, mr, md,
        input logic [31:0] fr, fd, lr, mv, ma, mdat, mw, g, be
    );
        vec_t v;
        v.fv  = fv[0];
        v.fa  = fa;
        v.fl  = fl[0];
        v.lv  = lv[0];
        v.la  = la;
        v.ld  = ld;
        v.h   = h[0];
        v.mr  = mr[0];
        v.md  = md;
        v.exp = {fr[0], fd, lr[0], mv[0], ma, mdat, mw[0], g[1:0], be[0]};
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iFetchValid = v.fv;
        iFetchAddr  = v.fa;
        iFetchFlush = v.fl;
        iLoadValid  = v.lv;
        iLoadAddr   = v.la;
        iLoadData   = v.ld;
        iHalt       = v.h;
        iMemReady   = v.mr;
        iMemData    = v.md;
    endtask

    task automatic next_cycle();
        @(posedge iClk);
        #1;
    endtask

    task automatic build();
        // reset -> fetch 0x10, ready on 4th grant cycle (timeout boundary)
        vq.push_back(mk(1,'h10,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1,'h10,0,0,0,0,0,0,0, 0,0,0,1,'h10,0,0,1,0));
        vq.push_back(mk(1,'h10,0,0,0,0,0,1,'hDEADBEEF,
                        1,'hDEADBEEF,0,1,'h10,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,'h10,0,0,0,0));
        // flush one cycle after grant, then clean fetch
        vq.push_back(mk(1,'h20,0,0,0,0,0,0,0, 0,0,0,0,'h10,0,0,0,0));
        vq.push_back(mk(1,'h20,1,0,0,0,0,0,0, 0,0,0,1,'h20,0,0,1,0));
        vq.push_back(mk(1,'h20,0,0,0,0,0,1,0, 0,0,0,1,'h20,0,0,1,0));
        vq.push_back(mk(1,'h24,0,0,0,0,0,0,0, 0,0,0,0,'h20,0,0,0,0));
        vq.push_back(mk(1,'h24,0,0,0,0,0,1,'hCAFEF00D,
                        1,'hCAFEF00D,0,1,'h24,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,'h24,0,0,0,0));
        // flush with ready; flush while idle ignored
        vq.push_back(mk(1,'h30,0,0,0,0,0,0,0, 0,0,0,0,'h24,0,0,0,0));
        vq.push_back(mk(1,'h30,1,0,0,0,0,1,0, 0,0,0,1,'h30,0,0,1,0));
        vq.push_back(mk(1,'h34,1,0,0,0,0,0,0, 0,0,0,0,'h30,0,0,0,0));
        vq.push_back(mk(1,'h34,0,0,0,0,0,1,'h11, 1,'h11,0,1,'h34,0,0,1,0));
        // load timeout, late ready ignored
        vq.push_back(mk(0,0,0,1,'h100,'hAA55AA55,0,0,0,
                        0,0,0,0,'h34,0,0,0,0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(0,0,0,1,'h100,'hAA55AA55,0,0,0,
                            0,0,0,1,'h100,'hAA55AA55,1,2,0));
        vq.push_back(mk(0,0,0,1,'h100,'hAA55AA55,0,1,0,
                        0,0,1,0,'h100,'hAA55AA55,1,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,1,0,
                        0,0,0,0,'h100,'hAA55AA55,1,0,0));
        // fetch timeout
        vq.push_back(mk(1,'h40,0,0,0,0,0,0,0,
                        0,0,0,0,'h100,'hAA55AA55,1,0,0));
        for (int i = 0; i < 4; i++)
            vq.push_back(mk(1,'h40,0,0,0,0,0,0,0, 0,0,0,1,'h40,0,0,1,0));
        vq.push_back(mk(1,'h40,0,0,0,0,0,0,0, 1,0,0,0,'h40,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,'h40,0,0,0,0));
        // dropped fetch timeout: error only
        vq.push_back(mk(1,'h44,0,0,0,0,0,0,0, 0,0,0,0,'h40,0,0,0,0));
        vq.push_back(mk(1,'h44,1,0,0,0,0,0,0, 0,0,0,1,'h44,0,0,1,0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1,'h44,0,0,0,0,0,0,0, 0,0,0,1,'h44,0,0,1,0));
        vq.push_back(mk(1,'h44,0,0,0,0,0,0,0, 0,0,0,0,'h44,0,0,0,1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,'h44,0,0,0,0));
        // halt: load only, fetch waits for halt release
        vq.push_back(mk(1,'h50,0,1,'h200,'h77,1,0,0,
                        0,0,0,0,'h44,0,0,0,0));
        vq.push_back(mk(1,'h50,0,1,'h200,'h77,1,1,0,
                        0,0,1,1,'h200,'h77,1,2,0));
        for (int i = 0; i < 2; i++)
            vq.push_back(mk(1,'h50,0,0,0,0,1,0,0,
                            0,0,0,0,'h200,'h77,1,0,0));
        vq.push_back(mk(1,'h50,0,0,0,0,0,0,0, 0,0,0,0,'h200,'h77,1,0,0));
        vq.push_back(mk(1,'h50,0,0,0,0,1,1,'h5, 1,'h5,0,1,'h50,0,0,1,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,'h50,0,0,0,0));
    endtask

    initial begin
        logic [69:0] cexp;
        build();
        iRst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0));
        next_cycle();
        chk("reset", outs(), '0);
        #2;
        iRst_n = 1'b1;
        next_cycle();

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            @(negedge iClk);
            chk($sformatf("vec%0d", i), outs(), vq[i].exp);
            next_cycle();
        end

        // contention: 8 fetch grants then 1 load, repeated
        iFetchValid = 1'b1;
        iFetchAddr  = 32'h60;
        iLoadValid  = 1'b1;
        iLoadAddr   = 32'h400;
        iLoadData   = 32'h0BADF00D;
        for (int k = 0; k < 18; k++) begin
            iMemReady = 1'b0;
            @(negedge iClk);
            chk($sformatf("cont_idle%0d", k), {oMemValid, oGrant}, '0);
            next_cycle();
            iMemReady = 1'b1;
            iMemData  = 32'(k);
            if (k % 9 == 8)
                cexp = {2'b10, 1'b1, 32'h400, 32'h0BADF00D, 1'b0, 1'b1};
            else
                cexp = {2'b01, 1'b0, 32'h60, 32'h0, 1'b1, 1'b0};
            @(negedge iClk);
            chk($sformatf("cont_gnt%0d", k),
                {oGrant, oMemWrite, oMemAddress, oMemData,
                 oFetchReady, oLoadReady}, cexp);
            next_cycle();
        end
        iFetchValid = 1'b0;
        iLoadValid  = 1'b0;
        iMemReady   = 1'b0;
        next_cycle();

        // async reset mid-load
        iLoadValid = 1'b1;
        iLoadAddr  = 32'h300;
        iLoadData  = 32'h99;
        next_cycle();
        @(negedge iClk);
        chk("rst_pre", {oMemValid, oGrant}, {1'b1, 2'b10});
        #2;
        iRst_n    = 1'b0;
        iMemReady = 1'b1;
        #1;
        chk("rst_async",
            {oMemValid, oGrant, oLoadReady, oMemAddress, oMemWrite}, '0);
        iLoadValid = 1'b0;
        next_cycle();
        iRst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge iClk);
            chk($sformatf("rst_after%0d", i),
                {oLoadReady, oFetchReady, oBusErr, oMemValid}, '0);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_mem_arbiter.md
Name: instr_mem_arbiter

Overview:
Shares the single instruction-memory port between the fetch stage (read-only) and the program loader (boot/refill writes). One transaction is outstanding at a time; the grant is held until memory ready or a timeout. Fetch has priority, bounded by a loader starvation counter. Sits between the fetch stage's memory address/valid/ready signals and the instruction memory.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, instruction/data width
STARVE_MAX, 8, consecutive fetch grants allowed while loader waits (1..255)
TIMEOUT, 255, cycles in a grant state without iMemReady before abort (1..255)

Ports:
iClk  in  1  clock, rising edge
iRst_n  in  1  reset, asynchronous, active-low
iFetchValid  in  1  fetch request; held with address until oFetchReady
iFetchAddr  in  ADDR_W  fetch address
iFetchFlush  in  1  pipeline redirect; discard in-flight fetch result
oFetchReady  out  1  one-cycle pulse: fetch transaction complete
oFetchData  out  DATA_W  read data, valid with oFetchReady
iLoadValid  in  1  loader write request; held until oLoadReady
iLoadAddr  in  ADDR_W  loader write address
iLoadData  in  DATA_W  loader write data
oLoadReady  out  1  one-cycle pulse: write complete
iHalt  in  1  blocks new fetch grants; loader still served
oMemAddress  out  ADDR_W  memory address, registered
oMemData  out  DATA_W  memory write data, registered
oMemWrite  out  1  1 = write (loader), 0 = read (fetch)
oMemValid  out  1  transaction active
iMemData  in  DATA_W  memory read data
iMemReady  in  1  memory completion, single-cycle pulse
oGrant  out  2  01 = fetch, 10 = loader, 00 = idle
oBusErr  out  1  pulses with the requester ready when a transaction times out

Behaviour:
- Reset (async, iRst_n=0): state IDLE. All outputs 0. Starvation counter, timeout counter and drop flag cleared. Reset mid-transaction abandons it silently, with no ready pulse.
- States: IDLE, GNT_FETCH, GNT_LOAD.
- IDLE arbitration, evaluated each cycle:
  - loadWin = iLoadValid && (starve >= STARVE_MAX || !iFetchValid || iHalt).
  - If loadWin: go to GNT_LOAD. Else if iFetchValid && !iHalt: go to GNT_FETCH. Else stay in IDLE.
- On a grant, oMemAddress, oMemData and oMemWrite are registered from the winner. oMemValid=1 from the next cycle, so request-to-memory latency is 1 cycle. oGrant follows the state.
- In a grant state, oMemValid=1 and outputs are held stable. oMemAddress, oMemData and oMemWrite are not re-sampled while granted.
- Completion: iMemReady=1 in GNT_FETCH produces oFetchReady=iMemReady & !drop and oFetchData=iMemData, both combinational. In GNT_LOAD it produces oLoadReady=1. The next state is IDLE, with oMemValid=0 for at least one cycle between transactions.
- Outside its completing cycle, oFetchData=0.
- Flush:
  - iFetchFlush in GNT_FETCH sets drop. The memory transaction still completes, but oFetchReady is suppressed.
  - drop is cleared on leaving GNT_FETCH.
  - iFetchFlush in the same cycle as iMemReady also suppresses the ready.
  - In IDLE or GNT_LOAD, iFetchFlush has no effect.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each fetch grant issued while iLoadValid=1.
  - Cleared on a loader grant or whenever iLoadValid=0.
  - Width 8 bits.
- Timeout:
  - A counter starts at 0 on grant entry and increments each grant cycle without iMemReady.
  - At TIMEOUT, the state returns to IDLE. The requester's ready pulses with oBusErr=1 for that cycle and oFetchData=0. A dropped fetch gets no ready but still pulses oBusErr.
  - An iMemReady arriving after the abort is ignored in IDLE.
- Simultaneous events:
  - iMemReady and timeout in the same cycle: the ready wins, with no error.
  - A requester dropping valid mid-grant is illegal. The transaction still completes.
- iHalt asserted while in GNT_FETCH does not abort the fetch. It only blocks future fetch grants.

Test Plan:
- Reset then fetch: iFetchValid=1, addr 0x10, memory ready 3 cycles after oMemValid. Required: oMemValid rises 1 cycle after request, oMemAddress=0x10, oMemWrite=0, oFetchReady pulses with iMemData=0xDEADBEEF, oGrant=01, then IDLE.
- Contention: fetch and load valid continuously with STARVE_MAX=8, memory ready in 1 cycle. Required: 8 fetch grants, then 1 load grant (oMemWrite=1, oMemData=iLoadData); the pattern repeats.
- Flush: iFetchFlush pulsed 1 cycle after the fetch grant. Required: iMemReady arrives, oFetchReady stays 0, state returns to IDLE, and the next fetch completes normally.
- Timeout: TIMEOUT=4, iMemReady never asserted on a load. Required: after 4 grant cycles, oLoadReady=1 and oBusErr=1 for one cycle, oGrant=00. A late iMemReady is ignored.
- Halt: iHalt=1 with fetch and load valid. Required: only load is granted; no fetch grant until iHalt=0.
- Async reset mid-GNT_LOAD: iRst_n low between clock edges. Required: oMemValid, oGrant and oLoadReady go to 0 immediately; no ready is pulsed after release.
